// File: rtl/rgb_fade_sequencer.sv
// RGB fade sequencer: accepts a target colour, ramps the three duty values toward it
// one step per prescaler tick, holds for a programmed number of ticks, then pulses done.
module rgb_fade_sequencer #(
  parameter int TICK_DIV = 100000,
  parameter int TICK_W   = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tgt_r,
  input  logic [7:0] tgt_g,
  input  logic [7:0] tgt_b,
  input  logic [7:0] fade_step,
  input  logic [7:0] hold_ticks,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  input  logic       abort,
  output logic [7:0] r_duty,
  output logic [7:0] g_duty,
  output logic [7:0] b_duty,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [TICK_W-1:0] presc;
  logic              tick;
  logic              accept;
  logic              at_target;
  logic              done_next;
  logic [7:0]        tgt_r_q;
  logic [7:0]        tgt_g_q;
  logic [7:0]        tgt_b_q;
  logic [7:0]        step_q;
  logic [7:0]        hold_len;
  logic [7:0]        hold_cnt;
  logic [7:0]        r_next;
  logic [7:0]        g_next;
  logic [7:0]        b_next;

  // One channel moves by step toward its target, snapping onto it when within one step.
  function automatic logic [7:0] approach(input logic [7:0] cur, input logic [7:0] tgt,
                                          input logic [7:0] step);
    logic signed [8:0] diff;
    logic [8:0]        mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[8] ? $unsigned(-diff) : $unsigned(diff);
    if (mag <= {1'b0, step}) begin
      approach = tgt;
    end else if (diff[8]) begin
      approach = cur - step;
    end else begin
      approach = cur + step;
    end
  endfunction

  assign tick      = (state != IDLE) && (presc == TICK_W'(TICK_DIV - 1));
  assign accept    = tgt_valid && tgt_ready;
  assign r_next    = approach(r_duty, tgt_r_q, step_q);
  assign g_next    = approach(g_duty, tgt_g_q, step_q);
  assign b_next    = approach(b_duty, tgt_b_q, step_q);
  assign at_target = (r_next == tgt_r_q) && (g_next == tgt_g_q) && (b_next == tgt_b_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Abort always beats a coinciding tick, so it is tested before any tick-driven transition.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = FADE;
        end
      end
      FADE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (tick && at_target) begin
          if (hold_len == 8'd0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (tick && (hold_cnt <= 8'd1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    tgt_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty   <= 8'd0;
      g_duty   <= 8'd0;
      b_duty   <= 8'd0;
      tgt_r_q  <= 8'd0;
      tgt_g_q  <= 8'd0;
      tgt_b_q  <= 8'd0;
      step_q   <= 8'd1;
      hold_len <= 8'd0;
      hold_cnt <= 8'd0;
      presc    <= '0;
      done     <= 1'b0;
    end else begin
      done <= done_next;
      if (accept) begin
        tgt_r_q  <= tgt_r;
        tgt_g_q  <= tgt_g;
        tgt_b_q  <= tgt_b;
        step_q   <= (fade_step == 8'd0) ? 8'd1 : fade_step;
        hold_len <= hold_ticks;
        presc    <= '0;
      end else if ((state != IDLE) && !abort) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick && (state == FADE)) begin
          r_duty <= r_next;
          g_duty <= g_next;
          b_duty <= b_next;
          if (at_target) begin
            hold_cnt <= hold_len;
          end
        end
        if (tick && (state == HOLD)) begin
          hold_cnt <= hold_cnt - 8'd1;
        end
      end else begin
        presc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench for rgb_fade_sequencer: duty trajectory and done timing come from a
// closed-form model (duty after k ticks, total fade ticks from the largest channel distance).
module tb_rgb_fade_sequencer;

  localparam int TD = 4;

  typedef struct {
    int r;
    int g;
    int b;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tgt_r, tgt_g, tgt_b, fade_step, hold_ticks;
  logic       tgt_valid, tgt_ready, abort;
  logic [7:0] r_duty, g_duty, b_duty;
  logic       busy, done;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   mon_on = 1'b0;
  bit   have_txn = 1'b0;
  bit   t_aborted = 1'b0;
  int   t_acc, t_end, t_st;
  int   t_sr, t_sg, t_sb, t_tr, t_tg, t_tb;
  int   model_r = 0, model_g = 0, model_b = 0;
  int   m_k, m_r, m_g, m_b;
  bit   m_busy;
  exp_t sb[$];
  exp_t m_e;

  always #5 clk = ~clk;

  rgb_fade_sequencer #(.TICK_DIV(TD), .TICK_W(3)) dut (
    .clk(clk), .rst(rst),
    .tgt_r(tgt_r), .tgt_g(tgt_g), .tgt_b(tgt_b),
    .fade_step(fade_step), .hold_ticks(hold_ticks),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .abort(abort),
    .r_duty(r_duty), .g_duty(g_duty), .b_duty(b_duty),
    .busy(busy), .done(done)
  );

  function automatic int model_duty(int s, int t, int st, int k);
    int stp;
    int m;
    stp = (st == 0) ? 1 : st;
    m = k * stp;
    if (t >= s) return (m >= t - s) ? t : s + m;
    return (m >= s - t) ? t : s - m;
  endfunction

  function automatic int chan_ticks(int s, int t, int st);
    int stp;
    int d;
    stp = (st == 0) ? 1 : st;
    d = (t > s) ? t - s : s - t;
    return (d + stp - 1) / stp;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every cycle against the model and consumes done pulses from the scoreboard.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (mon_on) begin
      if (have_txn) begin
        if (cyc < t_end) m_k = (cyc - t_acc) / TD;
        else if (t_aborted) m_k = (t_end - 1 - t_acc) / TD;
        else m_k = (t_end - t_acc) / TD;
        m_r = model_duty(t_sr, t_tr, t_st, m_k);
        m_g = model_duty(t_sg, t_tg, t_st, m_k);
        m_b = model_duty(t_sb, t_tb, t_st, m_k);
        m_busy = (cyc < t_end);
      end else begin
        m_r = model_r;
        m_g = model_g;
        m_b = model_b;
        m_busy = 1'b0;
      end
      checkOutput("duty_rgb", int'({r_duty, g_duty, b_duty}), (m_r << 16) | (m_g << 8) | m_b);
      checkOutput("busy_ready", int'({busy, tgt_ready}), m_busy ? 2 : 1);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          m_e = sb.pop_front();
          checkOutput("done_cycle", cyc, m_e.cyc);
          checkOutput("done_duty", int'({r_duty, g_duty, b_duty}), (m_e.r << 16) | (m_e.g << 8) | m_e.b);
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        checkOutput("missing_done", 0, 1);
        m_e = sb.pop_front();
      end
    end
  end

  // kill_mode: 0 run to completion, 1 abort, 2 reset; the kill lands at edge acc+kill_at.
  task automatic applyStimulus(input int r, input int g, input int b, input int st, input int hold,
                               input int kill_mode, input int kill_at, input bit junk);
    int   waited;
    int   n;
    int   ea;
    exp_t e;
    waited = 0;
    while (tgt_ready !== 1'b1 && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_wait", int'(tgt_ready), 1);
    if (tgt_ready !== 1'b1) return;
    n = chan_ticks(model_r, r, st);
    if (chan_ticks(model_g, g, st) > n) n = chan_ticks(model_g, g, st);
    if (chan_ticks(model_b, b, st) > n) n = chan_ticks(model_b, b, st);
    if (n < 1) n = 1;
    t_sr = model_r; t_sg = model_g; t_sb = model_b;
    t_tr = r; t_tg = g; t_tb = b; t_st = st;
    t_acc = cyc + 1;
    t_end = t_acc + (n + hold) * TD;
    t_aborted = 1'b0;
    have_txn = 1'b1;
    tgt_r = 8'(r); tgt_g = 8'(g); tgt_b = 8'(b);
    fade_step = 8'(st); hold_ticks = 8'(hold);
    tgt_valid = 1'b1;
    if (kill_mode == 0) begin
      e.r = r; e.g = g; e.b = b; e.cyc = t_end;
      sb.push_back(e);
    end
    @(negedge clk);
    tgt_valid = 1'b0;
    tgt_r = 8'($urandom); tgt_g = 8'($urandom); tgt_b = 8'($urandom);
    fade_step = 8'($urandom); hold_ticks = 8'($urandom);
    if (junk) begin
      while (cyc < t_acc + 5) @(negedge clk);
      tgt_valid = 1'b1;
      checkOutput("ready_while_busy", int'(tgt_ready), 0);
      @(negedge clk);
      tgt_valid = 1'b0;
    end
    if (kill_mode == 0) begin
      while (cyc < t_end) @(negedge clk);
      model_r = r; model_g = g; model_b = b;
    end else begin
      ea = t_acc + kill_at;
      while (cyc < ea - 1) @(negedge clk);
      if (kill_mode == 1) begin
        model_r = model_duty(t_sr, r, st, (ea - 1 - t_acc) / TD);
        model_g = model_duty(t_sg, g, st, (ea - 1 - t_acc) / TD);
        model_b = model_duty(t_sb, b, st, (ea - 1 - t_acc) / TD);
        t_end = ea;
        t_aborted = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end else begin
        have_txn = 1'b0;
        model_r = 0; model_g = 0; model_b = 0;
        sb.delete();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r, g, b, st, hold, n, tot;
    rst = 1'b1; abort = 1'b0; tgt_valid = 1'b0;
    tgt_r = 8'd0; tgt_g = 8'd0; tgt_b = 8'd0; fade_step = 8'd0; hold_ticks = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_duty", int'({r_duty, g_duty, b_duty}), 0);
    checkOutput("reset_ready", int'(tgt_ready), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    mon_on = 1'b1;

    applyStimulus(10, 0, 255, 5, 2, 0, 0, 1'b0);
    applyStimulus(0, 3, 250, 4, 0, 0, 0, 1'b0);
    applyStimulus(2, 3, 250, 0, 1, 0, 0, 1'b1);
    applyStimulus(0, 0, 0, 255, 0, 0, 0, 1'b0);
    applyStimulus(200, 0, 0, 1, 3, 1, 20 * TD + 1, 1'b0);
    checkOutput("abort_freeze_r", int'(r_duty), 20);
    checkOutput("abort_ready", int'(tgt_ready), 1);
    applyStimulus(50, 60, 70, 255, 5, 2, 3 * TD, 1'b0);
    checkOutput("reset_hold_duty", int'({r_duty, g_duty, b_duty}), 0);
    applyStimulus(100, 100, 100, 255, 0, 0, 0, 1'b0);
    applyStimulus(100, 100, 100, 7, 1, 0, 0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 255);
      g = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
      hold = $urandom_range(0, 15);
      n = chan_ticks(model_r, r, st);
      if (chan_ticks(model_g, g, st) > n) n = chan_ticks(model_g, g, st);
      if (chan_ticks(model_b, b, st) > n) n = chan_ticks(model_b, b, st);
      if (n < 1) n = 1;
      tot = (n + hold) * TD;
      if ($urandom_range(0, 4) == 0) applyStimulus(r, g, b, st, hold, 1, $urandom_range(1, tot), 1'b0);
      else applyStimulus(r, g, b, st, hold, 0, 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rgb_fade_sequencer.md
Name: rgb_fade_sequencer

Overview:
Upstream stage of the RGB PWM LED driver. Accepts target colours over a valid/ready handshake. Ramps three 8-bit duty values linearly toward each target at a programmable step per time tick. Holds the colour for a programmable number of ticks, then signals completion. The duty outputs connect directly to the PWM driver's R/G/B time inputs.

Parameters:
- TICK_DIV, 100000, clk cycles per fade/hold tick (1 kHz at 100 MHz); must be ≥2.
- TICK_W, 17, width of the prescaler counter; must hold TICK_DIV-1.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous reset, active-high.
- tgt_r  in  8  target red duty.
- tgt_g  in  8  target green duty.
- tgt_b  in  8  target blue duty.
- fade_step  in  8  per-tick increment magnitude; 0 treated as 1.
- hold_ticks  in  8  ticks to hold after reaching target.
- tgt_valid  in  1  target/step/hold fields valid.
- tgt_ready  out  1  high only in IDLE.
- abort  in  1  synchronous abort of a fade or hold.
- r_duty  out  8  red duty to PWM driver (registered).
- g_duty  out  8  green duty to PWM driver (registered).
- b_duty  out  8  blue duty to PWM driver (registered).
- busy  out  1  high in FADE or HOLD.
- done  out  1  one-cycle pulse when hold completes.

Behaviour:
- Reset (rst=1 at a clk edge): duties=0, state=IDLE, prescaler=0, hold counter=0, done=0. Cycle after reset: tgt_ready=1, busy=0. Reset overrides abort and tgt_valid.
- Prescaler: cleared on acceptance. Counts 0..TICK_DIV-1 in FADE/HOLD. tick=1 on the cycle it equals TICK_DIV-1, then wraps to 0. Held at 0 in IDLE.
- IDLE:
  - tgt_ready=1.
  - On tgt_valid&tgt_ready at an edge: latch targets, step (0→1), hold_ticks; go to FADE.
  - Duties keep their prior values.
- FADE, each tick, per channel independently:
  - Compute 9-bit signed diff = target - current.
  - If |diff| ≤ step: current←target. Else current←current ± step.
  - No wrap-around; values stay within 0..255 by construction.
  - If all three channels equal target after the update: go to HOLD with hold counter ← hold_ticks.
  - Special case hold_ticks=0: pulse done on the next cycle and go to IDLE directly.
  - A target equal to the current value still spends exactly one tick in FADE.
- HOLD: on each tick, decrement the hold counter. When it reaches 0, pulse done for 1 cycle and go to IDLE.
- Latency: first duty change occurs TICK_DIV cycles after acceptance. All duty updates occur on tick edges only.
- abort=1 in FADE/HOLD: go to IDLE next edge; duties frozen at current values; no done. Abort is ignored in IDLE.
- tgt_valid while busy: ignored, not queued. The producer must hold valid until ready.
- Simultaneous abort and tick: abort wins, no duty update.
- done and tgt_ready may both be 1 in the same cycle. An accept in that cycle is legal.

Test Plan (TICK_DIV=4):
- Reset: assert rst 2 cycles -> duties 0/0/0, tgt_ready=1, busy=0, done=0.
- Accept (10,0,255), step=5, hold=2 from 0/0/0 -> R=5,10 after ticks 1,2; B=255 at tick 51; HOLD 2 ticks; done pulses once at 53*4 cycles after accept; ready returns.
- From (10,0,255) target (0,3,250), step=4, hold=0 -> R 6,2,0; G 3; B 251,250; done 1 cycle after tick 3.
- step=0, target +2 on red, hold=1 -> red +1 per tick (2 ticks), done after tick 3. tgt_valid pulsed mid-fade with other data -> ignored, ready=0.
- Abort at tick 20 of a 0→200 step-1 fade -> red frozen at 20, no done, ready=1 next cycle. rst mid-HOLD -> all duties 0 next cycle.
- Target equal to current (100,100,100), hold=1 -> duties unchanged; HOLD entered at tick 1; done after tick 2.
